clk_div_cfg_arb: RTL and testbench

//  Owns the configuration port of an integer clock divider (div/clk_init/valid/ready/done) and

---
 rtl/clk_div_cfg_arb.sv | 191 +++++++++++++++++++
 tb/tb_clk_div_cfg_arb.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_cfg_arb.sv
// Round-robin owner of a clock divider's configuration port. Each granted request is
// applied glitch-free: gate the divided clock, load, wait for done, ungate, acknowledge.
module clk_div_cfg_arb #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned DIV_VALUE_WIDTH = 32,
    parameter int unsigned GATE_CYCLES     = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 256,
    parameter int unsigned RESET_DIV       = 0
) (
    input  logic                               clk_i,
    input  logic                               rst_n_i,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ*DIV_VALUE_WIDTH-1:0] div_val_i,
    input  logic [NUM_REQ-1:0]                 clk_init_i,
    input  logic [NUM_REQ-1:0]                 force_i,
    output logic [NUM_REQ-1:0]                 ack_o,
    output logic [NUM_REQ-1:0]                 err_o,
    output logic                               busy_o,
    output logic [DIV_VALUE_WIDTH-1:0]         div_o,
    output logic                               clk_init_o,
    output logic                               div_valid_o,
    input  logic                               div_ready_i,
    input  logic                               div_done_i,
    output logic                               clk_en_o
);
    localparam int unsigned CNT_MAX = (GATE_CYCLES > TIMEOUT_CYCLES) ? GATE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GATE,
        S_LOAD,
        S_WAIT,
        S_UNGATE,
        S_ACK
    } state_e;

    state_e                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_sat;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [PTR_W-1:0]            gnt_q, gnt_d;
    logic                        err_flag_q, err_flag_d;
    logic [DIV_VALUE_WIDTH-1:0]  div_q, div_d;
    logic                        init_q, init_d;
    logic                        clk_en_q, clk_en_d;
    logic                        valid_q, valid_d;
    logic [NUM_REQ-1:0]          ack_q, ack_d;
    logic [NUM_REQ-1:0]          err_q, err_d;
    logic                        busy_q, busy_d;

    logic                        win_found;
    logic [PTR_W-1:0]            win_idx;
    logic [DIV_VALUE_WIDTH-1:0]  win_div;

    // (ptr + ofs) mod NUM_REQ without a divider
    function automatic logic [PTR_W-1:0] rr_idx(input logic [PTR_W-1:0] ptr, input int unsigned ofs);
        int unsigned s;
        s = 32'(ptr) + ofs;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return PTR_W'(s);
    endfunction

    // Round-robin search starting at the pointer
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_i[rr_idx(ptr_q, i)]) begin
                win_found = 1'b1;
                win_idx   = rr_idx(ptr_q, i);
            end
        end
        win_div = div_val_i[32'(win_idx)*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH];
    end

    assign cnt_sat = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        err_flag_d = err_flag_q;
        div_d      = div_q;
        init_d     = init_q;
        clk_en_d   = clk_en_q;
        valid_d    = 1'b0;
        ack_d      = '0;
        err_d      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    gnt_d  = win_idx;
                    ptr_d  = rr_idx(win_idx, 1);
                    div_d  = win_div;
                    init_d = clk_init_i[win_idx];
                    if ((win_div == div_q) && !force_i[win_idx]) begin
                        state_d        = S_ACK;
                        ack_d[win_idx] = 1'b1;
                    end else begin
                        state_d  = S_GATE;
                        clk_en_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
            end
            S_GATE: begin
                if (cnt_q == CNT_W'(GATE_CYCLES - 1)) begin
                    state_d = S_LOAD;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            S_LOAD: begin
                if (div_ready_i) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_WAIT: begin
                // done has priority over a coincident timeout
                if (div_done_i) begin
                    state_d  = S_UNGATE;
                    clk_en_d = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = S_UNGATE;
                    clk_en_d   = 1'b1;
                    err_flag_d = 1'b1;
                end else begin
                    cnt_d = cnt_sat;
                end
            end
            S_UNGATE: begin
                state_d      = S_ACK;
                ack_d[gnt_q] = 1'b1;
                err_d[gnt_q] = err_flag_q;
            end
            S_ACK: begin
                state_d    = S_IDLE;
                err_flag_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            err_flag_q <= 1'b0;
            div_q      <= DIV_VALUE_WIDTH'(RESET_DIV);
            init_q     <= 1'b0;
            clk_en_q   <= 1'b1;
            valid_q    <= 1'b0;
            ack_q      <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            err_flag_q <= err_flag_d;
            div_q      <= div_d;
            init_q     <= init_d;
            clk_en_q   <= clk_en_d;
            valid_q    <= valid_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign ack_o       = ack_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;
    assign div_o       = div_q;
    assign clk_init_o  = init_q;
    assign div_valid_o = valid_q;
    assign clk_en_o    = clk_en_q;

endmodule

// File: tb/tb_clk_div_cfg_arb.sv
// Scoreboard bench for clk_div_cfg_arb: directed requests push expected acks, a monitor
// compares every ack (value, latency, gated-cycle and load-cycle counts) against them.
module tb_clk_div_cfg_arb;
    localparam int unsigned NR   = 2;
    localparam int unsigned W    = 32;
    localparam int unsigned GATE = 4;
    localparam int unsigned TOUT = 16;
    localparam logic [W-1:0] RST_DIV = '0;

    typedef struct {
        logic [NR-1:0] ack;
        logic          err;
        logic [W-1:0]  div;
        logic          init;
        int            lat;
        int            en_low;
        int            vcnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic              clk_i = 1'b0;
    logic              rst_n_i;
    logic [NR-1:0]     req_i, clk_init_i, force_i;
    logic [NR*W-1:0]   div_val_i;
    logic [NR-1:0]     ack_o, err_o;
    logic              busy_o, clk_init_o, div_valid_o, clk_en_o;
    logic [W-1:0]      div_o;
    logic              div_ready_i, div_done_i;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cfg, dwait_cfg, load_cnt, wait_cnt;
    int ptr_m, drv_timeouts;
    logic [W-1:0] cur_div;
    bit end_req, end_done;

    clk_div_cfg_arb #(
        .NUM_REQ(NR), .DIV_VALUE_WIDTH(W), .GATE_CYCLES(GATE),
        .TIMEOUT_CYCLES(TOUT), .RESET_DIV(0)
    ) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .req_i(req_i), .div_val_i(div_val_i),
        .clk_init_i(clk_init_i), .force_i(force_i), .ack_o(ack_o), .err_o(err_o),
        .busy_o(busy_o), .div_o(div_o), .clk_init_o(clk_init_o), .div_valid_o(div_valid_o),
        .div_ready_i(div_ready_i), .div_done_i(div_done_i), .clk_en_o(clk_en_o)
    );

    always #5 clk_i = ~clk_i;

    // Divider model: ready after stall_cfg cycles of valid, done dwait_cfg cycles after load
    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            load_cnt <= 0;
            wait_cnt <= 0;
        end else begin
            load_cnt <= (div_valid_o && !div_ready_i) ? load_cnt + 1 : 0;
            if (div_valid_o && div_ready_i) wait_cnt <= 1;
            else if (wait_cnt != 0 && wait_cnt < 1000) wait_cnt <= wait_cnt + 1;
        end
    end
    assign div_ready_i = div_valid_o && (load_cnt >= stall_cfg);
    assign div_done_i  = (dwait_cfg != 0) && (wait_cnt == dwait_cfg);

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor
    initial begin
        bit in_rst, busy_prev;
        int lat_c, en_low_c, vcnt_c;
        in_rst = 0; busy_prev = 0; lat_c = 0; en_low_c = 0; vcnt_c = 0; end_done = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_n_i) begin
                if (!in_rst) begin
                    chk("rst_div", div_o, RST_DIV);
                    chk("rst_clk_init", clk_init_o, 0);
                    chk("rst_clk_en", clk_en_o, 1);
                    chk("rst_valid", div_valid_o, 0);
                    chk("rst_ack", ack_o, 0);
                    chk("rst_err", err_o, 0);
                    chk("rst_busy", busy_o, 0);
                end
                in_rst = 1; busy_prev = 0; lat_c = 0; en_low_c = 0; vcnt_c = 0;
            end else begin
                if (in_rst) begin
                    chk("post_rst_div", div_o, RST_DIV);
                    chk("post_rst_clk_en", clk_en_o, 1);
                    chk("post_rst_busy", busy_o, 0);
                end
                in_rst = 0;
                if (busy_o && !busy_prev) lat_c = 1;
                else if (busy_o) lat_c++;
                busy_prev = busy_o;
                if (!clk_en_o) en_low_c++;
                if (div_valid_o) vcnt_c++;
                if (ack_o != '0) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_ack", ack_o, 0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        chk("ack", ack_o, mon_e.ack);
                        chk("err", err_o, {NR{mon_e.err}} & mon_e.ack);
                        chk("div", div_o, mon_e.div);
                        chk("clk_init", clk_init_o, mon_e.init);
                        chk("clk_en_at_ack", clk_en_o, 1);
                        chk("latency", lat_c, mon_e.lat);
                        chk("clk_en_low_cycles", en_low_c, mon_e.en_low);
                        chk("valid_cycles", vcnt_c, mon_e.vcnt);
                    end
                    en_low_c = 0;
                    vcnt_c   = 0;
                end
                if (end_req && !end_done) begin
                    chk("sb_empty", sb_q.size(), 0);
                    chk("drv_timeouts", drv_timeouts, 0);
                    end_done = 1;
                end
            end
        end
    end

    // Predict grant order and push expectations, then drive until every requester is acked
    task automatic issue(input logic [NR-1:0] mask, input logic [W-1:0] v0, input logic [W-1:0] v1,
                         input logic [NR-1:0] init, input logic [NR-1:0] frc,
                         input int stall, input int dwait);
        logic [NR-1:0] pend;
        logic [W-1:0]  vv;
        exp_t          e;
        int            g, dw;
        bit            tout, found;
        tout = (dwait == 0) || (dwait > TOUT);
        dw   = tout ? TOUT : dwait;
        pend = mask;
        while (pend != '0) begin
            found = 0;
            g     = 0;
            for (int k = 0; k < NR; k++) begin
                if (!found && pend[(ptr_m + k) % NR]) begin
                    found = 1;
                    g     = (ptr_m + k) % NR;
                end
            end
            vv     = (g == 0) ? v0 : v1;
            e.ack  = '0;
            e.ack[g] = 1'b1;
            e.div  = vv;
            e.init = init[g];
            if (vv == cur_div && !frc[g]) begin
                e.err = 0; e.lat = 1; e.en_low = 0; e.vcnt = 0;
            end else begin
                e.err = tout; e.lat = GATE + stall + dw + 3;
                e.en_low = GATE + 1 + stall + dw; e.vcnt = 1 + stall;
            end
            sb_q.push_back(e);
            cur_div = vv;
            ptr_m   = (g + 1) % NR;
            pend[g] = 1'b0;
        end
        @(negedge clk_i);
        stall_cfg  = stall;
        dwait_cfg  = dwait;
        div_val_i  = {v1, v0};
        clk_init_i = init;
        force_i    = frc;
        req_i      = mask;
        for (int c = 0; c < 300 && req_i != '0; c++) begin
            @(negedge clk_i);
            req_i = req_i & ~ack_o;
        end
        if (req_i != '0) begin
            drv_timeouts++;
            req_i = '0;
        end
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        rst_n_i = 1'b1; req_i = '0; div_val_i = '0; clk_init_i = '0; force_i = '0;
        stall_cfg = 0; dwait_cfg = 0; ptr_m = 0; cur_div = RST_DIV; drv_timeouts = 0; end_req = 0;
        #1 rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        repeat (2) @(negedge clk_i);

        issue(2'b11, 32'd2, 32'd5, 2'b10, 2'b00, 0, 3);   // simultaneous: req0 then req1
        issue(2'b01, 32'd3, 32'd0, 2'b00, 2'b00, 0, 5);   // single, done 5 cycles after load
        issue(2'b11, 32'd7, 32'd9, 2'b01, 2'b00, 0, 4);   // pointer now favours req1
        issue(2'b10, 32'd0, 32'd7, 2'b10, 2'b00, 0, 3);   // unchanged value: fast path
        issue(2'b01, 32'd7, 32'd0, 2'b00, 2'b01, 0, 2);   // unchanged value, forced
        issue(2'b10, 32'd0, 32'd11, 2'b00, 2'b00, 0, 0);  // done never rises: timeout
        issue(2'b01, 32'd4, 32'd0, 2'b01, 2'b00, 3, 2);   // ready stalls 3 cycles
        issue(2'b01, 32'd5, 32'd0, 2'b00, 2'b00, 0, 16);  // done on the last timeout cycle

        // Reset while waiting for done: sequence aborts with no ack
        @(negedge clk_i);
        stall_cfg = 0; dwait_cfg = 0;
        div_val_i = {32'd6, 32'd0}; clk_init_i = '0; force_i = '0; req_i = 2'b10;
        repeat (10) @(negedge clk_i);
        @(posedge clk_i);
        #2 rst_n_i = 1'b0;
        req_i = '0;
        repeat (3) @(posedge clk_i);
        #2 rst_n_i = 1'b1;
        ptr_m = 0;
        cur_div = RST_DIV;
        repeat (25) @(negedge clk_i);

        issue(2'b01, 32'd0, 32'd0, 2'b01, 2'b00, 0, 3);   // matches reset value: fast path
        issue(2'b11, 32'd8, 32'd8, 2'b11, 2'b00, 0, 1);   // second winner sees unchanged value

        end_req = 1;
        for (int c = 0; c < 50 && !end_done; c++) @(negedge clk_i);
        if (!end_done) begin
            $display("FAIL end_check: monitor did not complete final comparisons");
            $fatal(1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
